// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int DISP_W_DEF  = 8;

    // Increment values presented to program_counter while pc_inc is set
    localparam logic [7:0] PC_HOLD    = 8'h00;
    localparam logic [7:0] PC_ADVANCE = 8'h01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_target.sv
// Redirect detection and target selection: jump beats a taken branch.
// Latency: purely combinational.
// Backpressure: none; decision is made in the cycle the inputs are presented.
module branch_target_calc #(
    parameter int ADDR_W = 16,
    parameter int DISP_W = 8
) (
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [DISP_W-1:0] br_disp,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] disp_ext;

    // Sign-extend the displacement; the add wraps naturally modulo 2^ADDR_W
    always_comb begin
        disp_ext = {{(ADDR_W-DISP_W){br_disp[DISP_W-1]}}, br_disp};
        redirect = jmp_valid | (br_valid & br_taken);
        target   = jmp_valid ? jmp_target : (instr_addr + disp_ext);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers program_counter, reads instruction memory, hands words to decode.
// Latency: 3 cycles per instruction minimum (FETCH, WAIT, VALID).
// Backpressure: holds instr/instr_valid and the PC while instr_ready is low.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DISP_W  = DISP_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_inc,
    output logic [7:0]         pc_in,
    output logic [ADDR_W-1:0]  pc_din,
    output logic               pc_wEnb,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [DISP_W-1:0]  br_disp,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_target,
    input  logic               halt
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_addr_q, instr_addr_d;
    logic               instr_valid_q, instr_valid_d;

    logic               redirect;
    logic               redirect_ok;
    logic [ADDR_W-1:0]  target;

    branch_target_calc #(
        .ADDR_W (ADDR_W),
        .DISP_W (DISP_W)
    ) u_target (
        .instr_addr (instr_addr_q),
        .br_disp    (br_disp),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .redirect   (redirect),
        .target     (target)
    );

    // Next state, capture and PC control; PC is always held, advanced or loaded
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;
        pc_inc       = 1'b1;
        pc_in        = PC_HOLD;
        pc_wEnb      = 1'b0;
        pc_din       = '0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        redirect_ok  = redirect && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                state_d = halt ? HALTED : FETCH;
            end
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                state_d  = WAIT;
            end
            WAIT: begin
                // A redirect in this cycle makes the returning word stale
                if (!redirect_ok) begin
                    instr_d      = mem_data;
                    instr_addr_d = pc;
                    pc_in        = PC_ADVANCE;
                end
                state_d = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    state_d = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect loads the PC even when halting; it never advances in the same cycle
        if (redirect_ok) begin
            pc_inc  = 1'b0;
            pc_in   = PC_HOLD;
            pc_wEnb = 1'b1;
            pc_din  = target;
            state_d = halt ? HALTED : FETCH;
        end

        // While reset is low the PC is held and no memory read is issued
        if (!reset) begin
            pc_inc   = 1'b1;
            pc_in    = PC_HOLD;
            pc_wEnb  = 1'b0;
            pc_din   = '0;
            mem_rd   = 1'b0;
            mem_addr = '0;
        end

        instr_valid_d = (state_d == VALID);
    end

    // State and decode-facing registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_inc;
    logic [7:0]  pc_in;
    logic [15:0] pc_din;
    logic        pc_wEnb;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic        br_taken;
    logic [7:0]  br_disp;
    logic        jmp_valid;
    logic [15:0] jmp_target;
    logic        halt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .pc_in       (pc_in),
        .pc_din      (pc_din),
        .pc_wEnb     (pc_wEnb),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_disp     (br_disp),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .halt        (halt)
    );

    // Instruction memory contents: word = address ^ 16'hA001
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA001;
    endfunction

    // program_counter model: load, else add increment, else clear
    initial pc = 16'h0000;
    always @(posedge clk) begin
        if (pc_wEnb)     pc <= pc_din;
        else if (pc_inc) pc <= pc + {8'h00, pc_in};
        else             pc <= 16'h0000;
    end

    // Synchronous memory with one cycle read latency
    initial mem_data = 16'h0000;
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_word(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the PC contract is checked on every cycle out of reset
    task automatic tick();
        if (reset) check("pc_contract", {31'd0, pc_inc | pc_wEnb}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        br_disp     = 8'h00;
        jmp_valid   = 1'b0;
        jmp_target  = 16'h0000;
        halt        = 1'b0;

        // Reset state
        tick(); tick();
        settle();
        check("rst_instr",  instr, 16'h0000);
        check("rst_iaddr",  instr_addr, 16'h0000);
        check("rst_ivalid", instr_valid, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_maddr",  mem_addr, 16'h0000);
        check("rst_wenb",   pc_wEnb, 1'b0);
        check("rst_din",    pc_din, 16'h0000);
        check("rst_inc",    pc_inc, 1'b1);
        check("rst_in",     pc_in, 8'h00);

        // First fetch: IDLE, FETCH, WAIT, VALID
        reset = 1'b1; instr_ready = 1'b1;
        settle();
        check("idle_in",     pc_in, 8'h00);
        check("idle_mem_rd", mem_rd, 1'b0);
        tick(); settle();
        check("fetch_mem_rd", mem_rd, 1'b1);
        check("fetch_maddr",  mem_addr, 16'h0000);
        check("fetch_in",     pc_in, 8'h00);
        tick(); settle();
        check("wait_in",     pc_in, 8'h01);
        check("wait_ivalid", instr_valid, 1'b0);
        instr_ready = 1'b0;
        tick(); settle();
        check("v0_ivalid", instr_valid, 1'b1);
        check("v0_instr",  instr, 16'hA001);
        check("v0_iaddr",  instr_addr, 16'h0000);
        check("v0_pc",     pc, 16'h0001);

        // Decode stall for five cycles
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            check("stall_ivalid", instr_valid, 1'b1);
            check("stall_instr",  instr, 16'hA001);
            check("stall_pc",     pc, 16'h0001);
            check("stall_mem_rd", mem_rd, 1'b0);
        end
        instr_ready = 1'b1;
        tick(); settle();
        check("f1_maddr", mem_addr, 16'h0001);
        tick(); tick(); settle();
        check("v1_instr", instr, 16'hA000);
        check("v1_iaddr", instr_addr, 16'h0001);
        check("v1_pc",    pc, 16'h0002);

        // Jump to 0x0010 from VALID
        jmp_valid = 1'b1; jmp_target = 16'h0010;
        settle();
        check("j10_wenb", pc_wEnb, 1'b1);
        check("j10_inc",  pc_inc, 1'b0);
        check("j10_din",  pc_din, 16'h0010);
        tick(); jmp_valid = 1'b0; settle();
        check("j10_ivalid", instr_valid, 1'b0);
        check("j10_maddr",  mem_addr, 16'h0010);
        tick(); tick(); settle();
        check("v10_instr", instr, 16'hA011);
        check("v10_iaddr", instr_addr, 16'h0010);

        // Backward branch by -4
        br_valid = 1'b1; br_taken = 1'b1; br_disp = 8'hFC;
        settle();
        check("br_wenb", pc_wEnb, 1'b1);
        check("br_din",  pc_din, 16'h000C);
        tick(); br_valid = 1'b0; br_taken = 1'b0; settle();
        check("br_maddr",  mem_addr, 16'h000C);
        check("br_ivalid", instr_valid, 1'b0);

        // Jump and taken branch together during WAIT
        tick();
        jmp_valid = 1'b1; jmp_target = 16'h0200;
        br_valid = 1'b1; br_taken = 1'b1; br_disp = 8'hFC;
        settle();
        check("jw_din",  pc_din, 16'h0200);
        check("jw_wenb", pc_wEnb, 1'b1);
        tick();
        jmp_valid = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        settle();
        check("jw_instr_kept", instr, 16'hA011);
        check("jw_iaddr_kept", instr_addr, 16'h0010);
        check("jw_ivalid",     instr_valid, 1'b0);
        check("jw_maddr",      mem_addr, 16'h0200);
        tick(); tick(); settle();
        check("v200_instr", instr, 16'hA201);

        // Not-taken branch has no effect
        instr_ready = 1'b0; br_valid = 1'b1; br_taken = 1'b0; br_disp = 8'h10;
        settle();
        check("nt_wenb", pc_wEnb, 1'b0);
        check("nt_in",   pc_in, 8'h00);
        tick(); br_valid = 1'b0; settle();
        check("nt_ivalid", instr_valid, 1'b1);

        // Fetch at 0xFFFF: advance wraps to 0
        jmp_valid = 1'b1; jmp_target = 16'hFFFF;
        tick(); jmp_valid = 1'b0; instr_ready = 1'b1; settle();
        check("ff_maddr", mem_addr, 16'hFFFF);
        tick(); tick(); settle();
        check("ff_iaddr", instr_addr, 16'hFFFF);
        check("ff_instr", instr, 16'h5FFE);
        check("ff_pc",    pc, 16'h0000);

        // Displacement -128 from 0x0010 wraps below zero
        jmp_valid = 1'b1; jmp_target = 16'h0010;
        tick(); jmp_valid = 1'b0;
        tick(); tick(); settle();
        check("v10b_iaddr", instr_addr, 16'h0010);
        br_valid = 1'b1; br_taken = 1'b1; br_disp = 8'h80;
        settle();
        check("neg_din", pc_din, 16'hFF90);
        tick(); br_valid = 1'b0; br_taken = 1'b0; settle();
        check("neg_maddr", mem_addr, 16'hFF90);
        tick(); tick(); settle();
        check("vff90_pc", pc, 16'hFF91);

        // Halt after handoff, hold for ten cycles, then resume
        halt = 1'b1;
        settle();
        check("halt_v_in", pc_in, 8'h00);
        tick(); settle();
        check("halted_ivalid", instr_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            check("halted_pc",     pc, 16'hFF91);
            check("halted_mem_rd", mem_rd, 1'b0);
        end
        halt = 1'b0;
        tick(); settle();
        check("resume_mem_rd", mem_rd, 1'b1);
        check("resume_maddr",  mem_addr, 16'hFF91);

        // Reset in WAIT discards the capture
        tick();
        reset = 1'b0;
        settle();
        check("rw_in",   pc_in, 8'h00);
        check("rw_wenb", pc_wEnb, 1'b0);
        tick(); settle();
        check("rw_instr",  instr, 16'h0000);
        check("rw_iaddr",  instr_addr, 16'h0000);
        check("rw_ivalid", instr_valid, 1'b0);
        check("rw_mem_rd", mem_rd, 1'b0);
        reset = 1'b1;
        settle();
        check("rw_idle_mem_rd", mem_rd, 1'b0);
        tick(); settle();
        check("rw_fetch_maddr", mem_addr, 16'hFF91);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
